// File: rtl/riscv_ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I control unit.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEM_ADR,
        S_MEM_READ,
        S_MEM_WB,
        S_MEM_WRITE,
        S_EXEC_R,
        S_EXEC_I,
        S_ALU_WB,
        S_BEQ,
        S_JAL,
        S_LUI,
        S_JALR,
        S_JALR_LINK,
        S_TRAP
    } ctrl_state_e;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    // States that stall on the shared memory's ready handshake.
    function automatic logic is_mem_wait(input ctrl_state_e s);
        return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
    endfunction

endpackage

// File: rtl/ctrl_imm_decode.sv
// Opcode to immediate-format map; purely combinational so other cores can reuse it.
module ctrl_imm_decode
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] op_i,
    output logic [2:0] imm_src_o
);

    // Unknown opcodes fall back to the I format so the immediate path stays defined.
    always_comb begin
        imm_src_o = IMM_I;
        case (op_i)
            OP_SW:   imm_src_o = IMM_S;
            OP_BEQ:  imm_src_o = IMM_B;
            OP_JAL:  imm_src_o = IMM_J;
            OP_LUI:  imm_src_o = IMM_U;
            default: imm_src_o = IMM_I;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle RV32I datapath, with memory-wait timeout and traps.
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter bit          ENABLE_EXT = 1'b1,
    parameter int unsigned WAIT_LIMIT = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_read,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] result_src,
    output logic [2:0] imm_src,
    output logic       illegal_instr,
    output logic       bus_timeout,
    output logic       instr_done
);

    ctrl_state_e state_q, state_d;
    logic        illegal_q, illegal_d;
    logic        timeout_q, timeout_d;
    logic        timeout;

    logic       mem_read_s, mem_write_s, adr_src_s, ir_write_s, reg_write_s, done_s;
    logic       pc_update, branch;
    logic [1:0] src_a_s, src_b_s, alu_op_s, result_s;
    logic [2:0] imm_s;

    ctrl_imm_decode u_imm_decode (
        .op_i      (op),
        .imm_src_o (imm_s)
    );

    // The wait counter only exists when a limit is configured; it restarts on any state change.
    if (WAIT_LIMIT > 0) begin : g_wait
        localparam int CW = $clog2(WAIT_LIMIT + 1);
        logic [CW-1:0] wait_cnt_q, wait_cnt_d;
        logic          waiting;

        assign waiting    = is_mem_wait(state_q) && !mem_ready;
        assign timeout    = waiting && (wait_cnt_q == CW'(WAIT_LIMIT));
        assign wait_cnt_d = (waiting && (state_d == state_q)) ? wait_cnt_q + CW'(1) : '0;

        // Wait counter register.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) wait_cnt_q <= '0;
            else        wait_cnt_q <= wait_cnt_d;
        end
    end else begin : g_no_wait
        assign timeout = 1'b0;
    end

    assign illegal_d = illegal_q | ((state_q == S_DECODE) && (state_d == S_TRAP));
    assign timeout_d = timeout_q | timeout;

    // State and sticky trap flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state selection; a completed transfer always beats a timeout in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready)    state_d = S_DECODE;
                else if (timeout) state_d = S_TRAP;
            end
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEM_ADR;
                    OP_R:         state_d = S_EXEC_R;
                    OP_I:         state_d = S_EXEC_I;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    OP_LUI:       state_d = ENABLE_EXT ? S_LUI : S_TRAP;
                    OP_JALR:      state_d = ENABLE_EXT ? S_JALR : S_TRAP;
                    default:      state_d = S_TRAP;
                endcase
            end
            S_MEM_ADR:   state_d = (op == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ: begin
                if (mem_ready)    state_d = S_MEM_WB;
                else if (timeout) state_d = S_TRAP;
            end
            S_MEM_WB:    state_d = S_FETCH;
            S_MEM_WRITE: begin
                if (mem_ready)    state_d = S_FETCH;
                else if (timeout) state_d = S_TRAP;
            end
            S_EXEC_R:    state_d = S_ALU_WB;
            S_EXEC_I:    state_d = S_ALU_WB;
            S_ALU_WB:    state_d = S_FETCH;
            S_BEQ:       state_d = S_FETCH;
            S_JAL:       state_d = S_ALU_WB;
            S_LUI:       state_d = S_ALU_WB;
            S_JALR:      state_d = S_JALR_LINK;
            S_JALR_LINK: state_d = S_ALU_WB;
            S_TRAP:      state_d = S_TRAP;
            default:     state_d = S_FETCH;
        endcase
    end

    // Per-state datapath controls; only the handshake strobes look at mem_ready or zero.
    always_comb begin
        mem_read_s  = 1'b0;
        mem_write_s = 1'b0;
        adr_src_s   = 1'b0;
        ir_write_s  = 1'b0;
        reg_write_s = 1'b0;
        done_s      = 1'b0;
        pc_update   = 1'b0;
        branch      = 1'b0;
        src_a_s     = SRCA_PC;
        src_b_s     = SRCB_RS2;
        alu_op_s    = ALU_ADD;
        result_s    = RES_ALUOUT;
        case (state_q)
            S_FETCH: begin
                mem_read_s = 1'b1;
                src_b_s    = SRCB_FOUR;
                result_s   = RES_ALU;
                ir_write_s = mem_ready;
                pc_update  = mem_ready;
            end
            S_DECODE: begin
                src_a_s = SRCA_OLDPC;
                src_b_s = SRCB_IMM;
            end
            S_MEM_ADR: begin
                src_a_s = SRCA_RS1;
                src_b_s = SRCB_IMM;
            end
            S_MEM_READ: begin
                mem_read_s = 1'b1;
                adr_src_s  = 1'b1;
            end
            S_MEM_WB: begin
                result_s    = RES_DATA;
                reg_write_s = 1'b1;
                done_s      = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_write_s = 1'b1;
                adr_src_s   = 1'b1;
                done_s      = mem_ready;
            end
            S_EXEC_R: begin
                src_a_s  = SRCA_RS1;
                alu_op_s = ALU_FUNCT;
            end
            S_EXEC_I: begin
                src_a_s  = SRCA_RS1;
                src_b_s  = SRCB_IMM;
                alu_op_s = ALU_FUNCT;
            end
            S_ALU_WB: begin
                reg_write_s = 1'b1;
                done_s      = 1'b1;
            end
            S_BEQ: begin
                src_a_s  = SRCA_RS1;
                alu_op_s = ALU_SUB;
                branch   = 1'b1;
                done_s   = 1'b1;
            end
            S_JAL: begin
                src_a_s   = SRCA_OLDPC;
                src_b_s   = SRCB_FOUR;
                pc_update = 1'b1;
            end
            S_LUI: begin
                src_a_s = SRCA_ZERO;
                src_b_s = SRCB_IMM;
            end
            S_JALR: begin
                src_a_s   = SRCA_RS1;
                src_b_s   = SRCB_IMM;
                result_s  = RES_ALU;
                pc_update = 1'b1;
            end
            S_JALR_LINK: begin
                src_a_s = SRCA_OLDPC;
                src_b_s = SRCB_FOUR;
            end
            default: begin
                mem_read_s = 1'b0;
            end
        endcase
    end

    assign mem_read      = rst_n & mem_read_s;
    assign mem_write     = rst_n & mem_write_s;
    assign adr_src       = rst_n & adr_src_s;
    assign ir_write      = rst_n & ir_write_s;
    assign pc_write      = rst_n & (pc_update | (branch & zero));
    assign reg_write     = rst_n & reg_write_s;
    assign instr_done    = rst_n & done_s;
    assign alu_src_a     = rst_n ? src_a_s  : 2'b00;
    assign alu_src_b     = rst_n ? src_b_s  : 2'b00;
    assign alu_op        = rst_n ? alu_op_s : 2'b00;
    assign result_src    = rst_n ? result_s : 2'b00;
    assign imm_src       = rst_n ? imm_s    : 3'b000;
    assign illegal_instr = illegal_q;
    assign bus_timeout   = timeout_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench: two controller configurations run against a per-instruction step-list model.
module tb_multicycle_controller;

    localparam logic [6:0] LW   = 7'b0000011;
    localparam logic [6:0] SW   = 7'b0100011;
    localparam logic [6:0] RTY  = 7'b0110011;
    localparam logic [6:0] ITY  = 7'b0010011;
    localparam logic [6:0] BEQ  = 7'b1100011;
    localparam logic [6:0] JAL  = 7'b1101111;
    localparam logic [6:0] LUI  = 7'b0110111;
    localparam logic [6:0] JALR = 7'b1100111;
    localparam logic [6:0] SYS  = 7'b1110011;

    logic       clk = 1'b0;
    logic       rstN [2];
    logic       memReady;
    logic       zeroIn;
    logic [6:0] opIn [2];

    logic       memRead [2], memWrite [2], adrSrc [2], irWrite [2], pcWrite [2], regWrite [2];
    logic [1:0] aluSrcA [2], aluSrcB [2], aluOp [2], resultSrc [2];
    logic [2:0] immSrc [2];
    logic       illegalInstr [2], busTimeout [2], instrDone [2];

    int total = 0;
    int bad = 0;

    string      seq [2];
    int         pos [2];
    int         waited [2];
    bit         ill [2];
    bit         tmo [2];
    logic [6:0] pendOp [2];
    bit         pendValid [2];

    always #5 clk = ~clk;

    multicycle_controller #(.ENABLE_EXT(1'b1), .WAIT_LIMIT(0)) dutExt (
        .clk(clk), .rst_n(rstN[0]), .op(opIn[0]), .zero(zeroIn), .mem_ready(memReady),
        .mem_read(memRead[0]), .mem_write(memWrite[0]), .adr_src(adrSrc[0]),
        .ir_write(irWrite[0]), .pc_write(pcWrite[0]), .reg_write(regWrite[0]),
        .alu_src_a(aluSrcA[0]), .alu_src_b(aluSrcB[0]), .alu_op(aluOp[0]),
        .result_src(resultSrc[0]), .imm_src(immSrc[0]), .illegal_instr(illegalInstr[0]),
        .bus_timeout(busTimeout[0]), .instr_done(instrDone[0])
    );

    multicycle_controller #(.ENABLE_EXT(1'b0), .WAIT_LIMIT(2)) dutBase (
        .clk(clk), .rst_n(rstN[1]), .op(opIn[1]), .zero(zeroIn), .mem_ready(memReady),
        .mem_read(memRead[1]), .mem_write(memWrite[1]), .adr_src(adrSrc[1]),
        .ir_write(irWrite[1]), .pc_write(pcWrite[1]), .reg_write(regWrite[1]),
        .alu_src_a(aluSrcA[1]), .alu_src_b(aluSrcB[1]), .alu_op(aluOp[1]),
        .result_src(resultSrc[1]), .imm_src(immSrc[1]), .illegal_instr(illegalInstr[1]),
        .bus_timeout(busTimeout[1]), .instr_done(instrDone[1])
    );

    // Counts one comparison and reports it when observed and expected differ.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%05h expected=%05h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input bit mr, input bit z);
        memReady = mr;
        zeroIn   = z;
    endtask

    function automatic int limOf(input int i);
        return (i == 0) ? 0 : 2;
    endfunction

    function automatic bit extOf(input int i);
        return (i == 0);
    endfunction

    function automatic logic [2:0] immOf(input logic [6:0] o);
        case (o)
            SW:      return 3'b001;
            BEQ:     return 3'b010;
            JAL:     return 3'b011;
            LUI:     return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    // Step letters: F fetch, D decode, A address, R read, M load writeback, W write,
    // X reg-reg, I reg-imm, B alu writeback, Q branch, J jal, U lui, K jalr, L link, T trap.
    function automatic string planFor(input logic [6:0] o, input bit ext);
        case (o)
            LW:      return "DARM";
            SW:      return "DAW";
            RTY:     return "DXB";
            ITY:     return "DIB";
            BEQ:     return "DQ";
            JAL:     return "DJB";
            LUI:     return ext ? "DUB" : "DT";
            JALR:    return ext ? "DKLB" : "DT";
            default: return "DT";
        endcase
    endfunction

    function automatic logic [6:0] randOp();
        case ($urandom_range(0, 8))
            0:       return LW;
            1:       return SW;
            2:       return RTY;
            3:       return ITY;
            4:       return BEQ;
            5:       return JAL;
            6:       return LUI;
            7:       return JALR;
            default: return SYS;
        endcase
    endfunction

    function automatic byte curPh(input int i);
        return seq[i][pos[i]];
    endfunction

    // Output vector: rd,wr,adr,irw,pcw,regw,A,B,aluop,res,imm,illegal,timeout,done.
    function automatic logic [19:0] expVec(input byte ph, input bit mr, input bit z,
                                           input logic [6:0] o, input bit il, input bit tm);
        logic mrd, mwr, adr, irw, pcw, rw, dn;
        logic [1:0] a, b, aop, rs;
        mrd = 0; mwr = 0; adr = 0; irw = 0; pcw = 0; rw = 0; dn = 0;
        a = 0; b = 0; aop = 0; rs = 0;
        case (ph)
            "F": begin mrd = 1; b = 2'b10; rs = 2'b10; irw = mr; pcw = mr; end
            "D": begin a = 2'b01; b = 2'b01; end
            "A": begin a = 2'b10; b = 2'b01; end
            "R": begin mrd = 1; adr = 1; end
            "M": begin rs = 2'b01; rw = 1; dn = 1; end
            "W": begin mwr = 1; adr = 1; dn = mr; end
            "X": begin a = 2'b10; aop = 2'b10; end
            "I": begin a = 2'b10; b = 2'b01; aop = 2'b10; end
            "B": begin rw = 1; dn = 1; end
            "Q": begin a = 2'b10; aop = 2'b01; pcw = z; dn = 1; end
            "J": begin a = 2'b01; b = 2'b10; pcw = 1; end
            "U": begin a = 2'b11; b = 2'b01; end
            "K": begin a = 2'b10; b = 2'b01; rs = 2'b10; pcw = 1; end
            "L": begin a = 2'b01; b = 2'b10; end
            default: begin end
        endcase
        return {mrd, mwr, adr, irw, pcw, rw, a, b, aop, rs, immOf(o), il, tm, dn};
    endfunction

    function automatic logic [19:0] gotVec(input int i);
        return {memRead[i], memWrite[i], adrSrc[i], irWrite[i], pcWrite[i], regWrite[i],
                aluSrcA[i], aluSrcB[i], aluOp[i], resultSrc[i], immSrc[i],
                illegalInstr[i], busTimeout[i], instrDone[i]};
    endfunction

    task automatic modelReset(input int i);
        seq[i]       = "F";
        pos[i]       = 0;
        waited[i]    = 0;
        ill[i]       = 0;
        tmo[i]       = 0;
        pendValid[i] = 0;
    endtask

    // Advances the model by one clock given this cycle's mem_ready.
    task automatic modelStep(input int i, input bit mr);
        byte ph;
        bit  isWait;
        ph     = curPh(i);
        isWait = (ph == "F") || (ph == "R") || (ph == "W");
        if (ph == "T") return;
        if (isWait && !mr) begin
            if (limOf(i) > 0 && waited[i] == limOf(i)) begin
                seq[i]    = "T";
                pos[i]    = 0;
                waited[i] = 0;
                tmo[i]    = 1;
            end else begin
                waited[i]++;
            end
            return;
        end
        waited[i] = 0;
        if (ph == "F") begin
            pendOp[i]    = randOp();
            pendValid[i] = 1;
            seq[i]       = planFor(pendOp[i], extOf(i));
            pos[i]       = 0;
        end else begin
            pos[i]++;
            if (pos[i] >= seq[i].len()) begin
                seq[i] = "F";
                pos[i] = 0;
            end else if (curPh(i) == "T") begin
                ill[i] = 1;
            end
        end
    endtask

    // Main randomized run with occasional resets, including mid-write and after traps.
    initial begin
        bit doRst;
        applyStimulus(1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            opIn[i] = ITY;
            rstN[i] = 1'b1;
            modelReset(i);
        end
        #1;
        rstN[0] = 1'b0;
        rstN[1] = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        for (int i = 0; i < 2; i++) checkOutput($sformatf("reset_dut%0d", i), 32'(gotVec(i)), 32'h0);
        @(posedge clk);
        #1;
        rstN[0] = 1'b1;
        rstN[1] = 1'b1;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            applyStimulus($urandom_range(0, 9) < 6, 1'($urandom_range(0, 1)));
            #1;
            for (int i = 0; i < 2; i++)
                checkOutput($sformatf("dut%0d_ph%c_cyc%0d", i, curPh(i), cyc), 32'(gotVec(i)),
                            32'(expVec(curPh(i), memReady, zeroIn, opIn[i], ill[i], tmo[i])));
            for (int i = 0; i < 2; i++) begin
                doRst = (curPh(i) == "T" && $urandom_range(0, 2) == 0) ||
                        (curPh(i) == "W" && $urandom_range(0, 3) == 0) ||
                        ($urandom_range(0, 199) == 0);
                if (doRst) begin
                    rstN[i] = 1'b0;
                    #1;
                    checkOutput($sformatf("async_reset_dut%0d_cyc%0d", i, cyc), 32'(gotVec(i)), 32'h0);
                    modelReset(i);
                end else begin
                    modelStep(i, memReady);
                end
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                if (pendValid[i]) begin
                    opIn[i]      = pendOp[i];
                    pendValid[i] = 0;
                end
                if (!rstN[i]) rstN[i] = 1'b1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
